mem_sweep_ctrl: RTL and testbench
=================================

Name: mem_sweep_ctrl

Overview:
Controller that sequences an address counter to run a write-then-read-back sweep over a single-port memory of DEPTH words.
- Started by a one-cycle `start_i` pulse.
- Drives memory enable, write-enable, address and write data.
- Compares read data against the expected pattern and reports pass/fail, error count and first failing address with a one-cycle `done_o` pulse.
- Sits between the test/sequencing logic and the memory macro; the address counter is owned by this block.

Parameters:
ADDR_WIDTH, 7, address counter width; DEPTH must be <= 2**ADDR_WIDTH
DEPTH, 100, number of words swept (addresses 0..DEPTH-1)
DATA_WIDTH, 8, memory data width; DATA_WIDTH >= ADDR_WIDTH

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  start pulse; sampled only in IDLE
seed_i  input  DATA_WIDTH  pattern seed; latched on accepted start
hold_i  input  1  stall; freezes sweep while high
mem_en_o  output  1  memory access enable
mem_we_o  output  1  write enable (valid with mem_en_o)
mem_addr_o  output  ADDR_WIDTH  memory address
mem_wdata_o  output  DATA_WIDTH  write data
mem_rdata_i  input  DATA_WIDTH  read data, valid 1 cycle after read access
busy_o  output  1  high in WRITE, READ, DRAIN
done_o  output  1  one-cycle completion pulse
pass_o  output  1  1 when err_cnt_o == 0; updated at DONE
err_cnt_o  output  ADDR_WIDTH+1  mismatch count, saturating at all-ones
first_err_addr_o  output  ADDR_WIDTH  address of first mismatch; 0 if none

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=IDLE; all outputs 0; counter=0; seed latch=0. Reset mid-sweep aborts immediately: `mem_en_o` drops asynchronously and no `done_o` is produced.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - `start_i`=1 -> latch `seed_i`, clear counter, `err_cnt_o` and `first_err_addr_o`, go to WRITE.
  - `start_i` in any other state is ignored.
- Pattern: expected(a) = seed XOR zero-extend(a) to DATA_WIDTH.
- WRITE:
  - `mem_en_o`=1, `mem_we_o`=1, `mem_addr_o`=cnt, `mem_wdata_o`=expected(cnt).
  - Counter increments each non-held cycle.
  - At cnt==DEPTH-1 (non-held): counter clears to 0, go to READ.
- READ:
  - `mem_en_o`=1, `mem_we_o`=0, `mem_addr_o`=cnt; increments each non-held cycle.
  - At cnt==DEPTH-1 (non-held): go to DRAIN.
- Compare pipeline:
  - One register stage holds {rd_valid, rd_addr}; rd_valid = READ & ~hold_i.
  - In the cycle after a read access, `mem_rdata_i` is compared with expected(rd_addr).
  - On mismatch: `err_cnt_o` increments (saturating). If `err_cnt_o` was 0, `first_err_addr_o`=rd_addr.
- DRAIN: one cycle, no memory access; it consumes the last compare. Then go to DONE.
- DONE: one cycle; `done_o`=1, `pass_o`=(err_cnt==0 including the last compare); then go to IDLE.
- Result hold: `pass_o`, `err_cnt_o` and `first_err_addr_o` hold until the next accepted start.
- `hold_i`:
  - In WRITE/READ: `mem_en_o`=0, counter and state frozen, no compare issued for that cycle.
  - Ignored in IDLE, DRAIN, DONE.
  - An access already issued still completes its compare.
- Outputs outside WRITE/READ: `mem_en_o`=0, `mem_we_o`=0; `mem_addr_o` and `mem_wdata_o` are 0.
- Counter bounds: never exceeds DEPTH-1; no wrap. If DEPTH==2**ADDR_WIDTH, the terminal compare still uses DEPTH-1.
- Latency with no hold: start sampled at cycle 0; WRITE cycles 1..DEPTH; READ cycles DEPTH+1..2*DEPTH; DRAIN at 2*DEPTH+1; `done_o` at 2*DEPTH+2.
- All memory outputs are registered or decoded directly from state and counter, with no combinational path from inputs except `hold_i` -> `mem_en_o`.

Decomposition:
- Package mem_sweep_pkg holds:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - pattern function expected(seed, addr);
  - ERR_WIDTH = ADDR_WIDTH+1.
- One sub-module, sweep_addr_cnt:
  - ADDR_WIDTH-wide counter with inc_en, sync clear and terminal flag (cnt==DEPTH-1);
  - reused for both the write and read phases.

Test Plan:
1. Clean memory model, DEPTH=100, seed 0xA5, no hold. Required:
   - 100 writes with addr 0..99, wdata 0xA5^addr; then 100 reads;
   - `done_o` pulse exactly at cycle 202;
   - `pass_o`=1, `err_cnt_o`=0, `first_err_addr_o`=0.
2. Memory model corrupts reads at addresses 17 and 63 (bit 0 flipped) -> `pass_o`=0, `err_cnt_o`=2, `first_err_addr_o`=17.
3. `hold_i` high for 3 cycles mid-WRITE at cnt=40 and for 2 cycles in READ at cnt=99. Required:
   - `mem_en_o`=0 during holds; no address skipped or repeated;
   - `done_o` at cycle 207; result passes.
4. Error on the last address (99) only -> caught by the DRAIN compare: `err_cnt_o`=1, `first_err_addr_o`=99, `pass_o`=0.
5. `start_i` pulsed again during READ -> ignored, a single `done_o` only. `rst_n` low at cycle 50 -> all outputs 0 immediately, state IDLE; a new start after release produces a full 202-cycle run.
6. Every read returns 0 with seed 0xFF, DEPTH=100 -> `err_cnt_o`=100, `first_err_addr_o`=0; a separate saturation run with DEPTH=128 and ADDR_WIDTH=7 -> `err_cnt_o`=128 with no wrap.

Source files
------------

// File: rtl/mem_sweep_pkg.sv
// Shared types and helpers for the memory sweep controller.
package mem_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam int PAT_MAX = 64;

  // Error counter is one bit wider than the address so a full sweep of
  // 2**ADDR_WIDTH mismatches is representable without wrapping.
  function automatic int err_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [PAT_MAX-1:0] expected(input logic [PAT_MAX-1:0] seed,
                                                  input logic [PAT_MAX-1:0] addr);
    return seed ^ addr;
  endfunction

endpackage

// File: rtl/sweep_addr_cnt.sv
// Sweep address counter: counts 0..DEPTH-1, self-clears after the terminal count.
module sweep_addr_cnt #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc_en,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  assign last = (cnt == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc_en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_sweep_ctrl.sv
// Write-then-read-back memory sweep controller with a one-stage compare pipeline.
module mem_sweep_ctrl
  import mem_sweep_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 100,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic                  hold_i,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

  localparam int EW = err_width(ADDR_WIDTH);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   seed;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    last;
  logic                    rd_valid;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    access;
  logic                    step;
  logic                    mismatch;
  logic [DATA_WIDTH-1:0]   cnt_pat;
  logic [DATA_WIDTH-1:0]   rd_pat;
  logic [EW-1:0]           err_next;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [DATA_WIDTH-1:0] s,
                                                input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(expected(PAT_MAX'(s), PAT_MAX'(a)));
  endfunction

  assign access      = (state == WRITE) || (state == READ);
  assign step        = access && !hold_i;
  assign cnt_pat     = pat(seed, cnt);
  assign rd_pat      = pat(seed, rd_addr);

  assign mem_en_o    = step;
  assign mem_we_o    = (state == WRITE);
  assign mem_addr_o  = access ? cnt : '0;
  assign mem_wdata_o = (state == WRITE) ? cnt_pat : '0;
  assign busy_o      = access || (state == DRAIN);
  assign done_o      = (state == DONE);

  assign mismatch = rd_valid && (mem_rdata_i != rd_pat);
  assign err_next = (mismatch && !(&err_cnt_o)) ? err_cnt_o + 1'b1 : err_cnt_o;

  sweep_addr_cnt #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state == IDLE) && start_i),
    .inc_en(step),
    .cnt   (cnt),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      seed             <= '0;
      rd_valid         <= 1'b0;
      rd_addr          <= '0;
      pass_o           <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else begin
      rd_valid  <= (state == READ) && !hold_i;
      rd_addr   <= cnt;
      err_cnt_o <= err_next;
      if (mismatch && (err_cnt_o == '0)) begin
        first_err_addr_o <= rd_addr;
      end
      unique case (state)
        IDLE: begin
          if (start_i) begin
            seed             <= seed_i;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            pass_o           <= 1'b0;
            state            <= WRITE;
          end
        end
        WRITE: if (step && last) state <= READ;
        READ:  if (step && last) state <= DRAIN;
        // The last read's compare lands here, so the verdict uses err_next.
        DRAIN: begin
          pass_o <= (err_next == '0);
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Directed bench for mem_sweep_ctrl with a memory model and an access-sequence checker.
module tb_mem_sweep_ctrl;

  localparam int AW = 7;
  localparam int D  = 100;
  localparam int DW = 8;
  localparam int D2 = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [DW-1:0] seed_i = '0;
  logic          hold_i = 1'b0;
  logic          mem_en_o, mem_we_o, busy_o, done_o, pass_o;
  logic [AW-1:0] mem_addr_o, first_err_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic [AW:0]   err_cnt_o;

  logic          start2 = 1'b0;
  logic [DW-1:0] seed2 = 8'hFF;
  logic          hold2 = 1'b0;
  logic [DW-1:0] rdata2 = '0;
  logic          en2, we2, busy2, done2, pass2;
  logic [AW-1:0] addr2, first2;
  logic [DW-1:0] wdata2;
  logic [AW:0]   err2;

  always #5 clk = ~clk;

  mem_sweep_ctrl #(.ADDR_WIDTH(AW), .DEPTH(D), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .seed_i(seed_i), .hold_i(hold_i),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o),
    .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o)
  );

  mem_sweep_ctrl #(.ADDR_WIDTH(AW), .DEPTH(D2), .DATA_WIDTH(DW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .seed_i(seed2), .hold_i(hold2),
    .mem_en_o(en2), .mem_we_o(we2), .mem_addr_o(addr2),
    .mem_wdata_o(wdata2), .mem_rdata_i(rdata2), .busy_o(busy2),
    .done_o(done2), .pass_o(pass2), .err_cnt_o(err2),
    .first_err_addr_o(first2)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory model: writes stored, reads return stored ^ corrupt mask (or 0).
  logic [DW-1:0] mem     [0:D2-1];
  logic [DW-1:0] corrupt [0:D2-1];
  bit            zero_mode = 1'b0;
  bit            hold_sched [0:400];

  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      else mem_rdata_i <= zero_mode ? '0 : (mem[mem_addr_o] ^ corrupt[mem_addr_o]);
    end
  end

  typedef struct {
    bit we;
    int addr;
    int data;
  } acc_t;

  acc_t exp_q[$];
  bit   chk_on = 1'b0;

  always @(negedge clk) begin
    acc_t e;
    if (chk_on) begin
      if (mem_en_o) begin
        if (exp_q.size() == 0) begin
          chk("extra_access", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("acc_we", {31'd0, mem_we_o}, {31'd0, e.we});
          chk("acc_addr", 32'(mem_addr_o), e.addr);
          if (e.we) chk("acc_wdata", 32'(mem_wdata_o), e.data);
        end
      end
      if (hold_i) chk("en_in_hold", {31'd0, mem_en_o}, 32'd0);
      if (!busy_o) begin
        chk("quiet_we", {31'd0, mem_we_o}, 32'd0);
        chk("quiet_addr", 32'(mem_addr_o), 32'd0);
        chk("quiet_wdata", 32'(mem_wdata_o), 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string name);
    chk({name, "_en"}, {31'd0, mem_en_o}, 32'd0);
    chk({name, "_we"}, {31'd0, mem_we_o}, 32'd0);
    chk({name, "_addr"}, 32'(mem_addr_o), 32'd0);
    chk({name, "_wdata"}, 32'(mem_wdata_o), 32'd0);
    chk({name, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({name, "_done"}, {31'd0, done_o}, 32'd0);
    chk({name, "_pass"}, {31'd0, pass_o}, 32'd0);
    chk({name, "_err"}, 32'(err_cnt_o), 32'd0);
    chk({name, "_first"}, 32'(first_err_addr_o), 32'd0);
  endtask

  task automatic run(input string name, input logic [7:0] seed, input int restart_at,
                     input int reset_at, input int exp_done, input int exp_err,
                     input int exp_first);
    int m_err, m_first, done_cyc, ndone;
    logic [7:0] pr;
    logic r_pass;
    logic [AW:0] r_err;
    logic [AW-1:0] r_first;
    exp_q.delete();
    for (int a = 0; a < D; a++) exp_q.push_back('{we: 1'b1, addr: a, data: int'(seed ^ 8'(a))});
    for (int a = 0; a < D; a++) exp_q.push_back('{we: 1'b0, addr: a, data: 0});
    m_err = 0;
    m_first = 0;
    for (int a = 0; a < D; a++) begin
      pr = zero_mode ? 8'h00 : ((seed ^ 8'(a)) ^ corrupt[a]);
      if (pr != (seed ^ 8'(a))) begin
        if (m_err == 0) m_first = a;
        m_err++;
      end
    end
    if (m_err > 255) m_err = 255;
    r_pass = 1'b0;
    r_err = '0;
    r_first = '0;
    chk_on = 1'b1;
    seed_i = seed;
    start_i = 1'b1;
    done_cyc = -1;
    ndone = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      start_i = (k == restart_at);
      hold_i = hold_sched[k];
      if (k == reset_at) begin
        chk_on = 1'b0;
        hold_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero({name, "_rst"});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      if (done_o) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = k;
          r_pass = pass_o;
          r_err = err_cnt_o;
          r_first = first_err_addr_o;
        end
      end
      if (done_cyc > 0 && k >= done_cyc + 5) break;
    end
    chk_on = 1'b0;
    hold_i = 1'b0;
    chk({name, "_done_cycle"}, done_cyc, exp_done);
    chk({name, "_done_count"}, ndone, 32'd1);
    chk({name, "_accesses_left"}, exp_q.size(), 32'd0);
    chk({name, "_err_model"}, 32'(r_err), m_err);
    chk({name, "_err"}, 32'(r_err), exp_err);
    chk({name, "_first_model"}, 32'(r_first), m_first);
    chk({name, "_first"}, 32'(r_first), exp_first);
    chk({name, "_pass_model"}, {31'd0, r_pass}, {31'd0, m_err == 0});
    chk({name, "_pass"}, {31'd0, r_pass}, {31'd0, exp_err == 0});
    chk({name, "_err_held"}, 32'(err_cnt_o), 32'(r_err));
    chk({name, "_pass_held"}, {31'd0, pass_o}, {31'd0, r_pass});
    chk({name, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int d2_cyc;
    for (int a = 0; a < D2; a++) begin
      corrupt[a] = '0;
      mem[a] = '0;
    end
    for (int k = 0; k <= 400; k++) hold_sched[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("t1_clean", 8'hA5, 0, 0, 202, 0, 0);

    corrupt[17] = 8'h01;
    corrupt[63] = 8'h01;
    run("t2_two_err", 8'hA5, 0, 0, 202, 2, 17);
    corrupt[17] = '0;
    corrupt[63] = '0;

    for (int k = 41; k <= 43; k++) hold_sched[k] = 1'b1;
    hold_sched[203] = 1'b1;
    hold_sched[204] = 1'b1;
    run("t3_hold", 8'hA5, 0, 0, 207, 0, 0);
    for (int k = 0; k <= 400; k++) hold_sched[k] = 1'b0;

    corrupt[99] = 8'h01;
    run("t4_last", 8'h3C, 0, 0, 202, 1, 99);
    corrupt[99] = '0;

    run("t5_restart", 8'h5A, 150, 0, 202, 0, 0);
    run("t5_reset", 8'h5A, 0, 50, 0, 0, 0);
    run("t5_after_rst", 8'h5A, 0, 0, 202, 0, 0);

    zero_mode = 1'b1;
    run("t6_zero", 8'hFF, 0, 0, 202, 100, 0);
    zero_mode = 1'b0;

    start2 = 1'b1;
    d2_cyc = -1;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      #1;
      start2 = 1'b0;
      if (done2) begin
        d2_cyc = k;
        break;
      end
    end
    chk("t6_full_done_cycle", d2_cyc, 32'd258);
    chk("t6_full_err", 32'(err2), 32'd128);
    chk("t6_full_first", 32'(first2), 32'd0);
    chk("t6_full_pass", {31'd0, pass2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
